// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle controller.
// Optional MULTICYCLE_CTRL_MEM_READY_EN build adds memory wait states.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMREAD  = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWRITE = 4'd5,
    ST_EXECR    = 4'd6,
    ST_EXECI    = 4'd7,
    ST_ALUWB    = 4'd8,
    ST_BRANCH   = 4'd9
  } state_e;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_CMN = 4'b1011;

  localparam logic       ADR_PC  = 1'b0;
  localparam logic       ADR_ALU = 1'b1;

  localparam logic [1:0] SRCA_REG = 2'b00;
  localparam logic [1:0] SRCA_PC  = 2'b01;
  localparam logic [1:0] SRCA_ALU = 2'b10;

  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_4   = 2'b10;

  localparam logic [1:0] RES_OUT  = 2'b00;
  localparam logic [1:0] RES_DATA = 2'b01;
  localparam logic [1:0] RES_ALU  = 2'b10;

  typedef struct packed {
    logic       ir_write;
    logic       pc_fetch;
    logic       pc_branch;
    logic       reg_write;
    logic       mem_write;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       alu_op;
    logic [1:0] flag_write;
  } ctrl_t;

  function automatic logic is_cmp(input logic [3:0] cmd);
    return (cmd == CMD_CMP) || (cmd == CMD_CMN);
  endfunction

  function automatic logic is_arith(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB) || is_cmp(cmd);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Moore output decode: state and funct to raw, ungated strobes.
// Gating by cond_ex, reset and mem_ready happens in the top.
module multicycle_ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [3:0] i_state,
  input  logic [4:0] i_funct,
  output ctrl_t      o_ctrl
);

  logic [3:0] w_cmd;
  logic       w_s;

  assign w_cmd = i_funct[4:1];
  assign w_s   = i_funct[0];

  // Per-state raw outputs; anything not set stays 0
  always_comb begin
    o_ctrl = '0;
    case (i_state)
      ST_FETCH: begin
        o_ctrl.ir_write   = 1'b1;
        o_ctrl.pc_fetch   = 1'b1;
        o_ctrl.adr_src    = ADR_PC;
        o_ctrl.alu_src_a  = SRCA_PC;
        o_ctrl.alu_src_b  = SRCB_4;
        o_ctrl.result_src = RES_ALU;
      end
      ST_DECODE: begin
        o_ctrl.alu_src_a  = SRCA_PC;
        o_ctrl.alu_src_b  = SRCB_4;
        o_ctrl.result_src = RES_ALU;
      end
      ST_MEMADR: begin
        o_ctrl.alu_src_a = SRCA_REG;
        o_ctrl.alu_src_b = SRCB_IMM;
      end
      ST_MEMREAD: begin
        o_ctrl.adr_src = ADR_ALU;
      end
      ST_MEMWB: begin
        o_ctrl.result_src = RES_DATA;
        o_ctrl.reg_write  = 1'b1;
      end
      ST_MEMWRITE: begin
        o_ctrl.adr_src   = ADR_ALU;
        o_ctrl.mem_write = 1'b1;
      end
      ST_EXECR, ST_EXECI: begin
        o_ctrl.alu_src_b = (i_state == ST_EXECI)
                         ? SRCB_IMM : SRCB_REG;
        o_ctrl.alu_op        = 1'b1;
        o_ctrl.flag_write[1] = w_s;
        o_ctrl.flag_write[0] = w_s & is_arith(w_cmd);
      end
      ST_ALUWB: begin
        o_ctrl.reg_write = ~is_cmp(w_cmd);
      end
      ST_BRANCH: begin
        o_ctrl.alu_src_a  = SRCA_ALU;
        o_ctrl.alu_src_b  = SRCB_IMM;
        o_ctrl.result_src = RES_ALU;
        o_ctrl.pc_branch  = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle controller: state register, sequencing and strobe gating.
// Define MULTICYCLE_CTRL_MEM_READY_EN to stall on mem_ready.
module multicycle_ctrl_fsm
  import multicycle_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         op,
  input  logic [5:0]         funct,
  input  logic [3:0]         rd,
  input  logic               cond_ex,
  input  logic               mem_ready,
  output logic               ir_write,
  output logic               pc_write,
  output logic               reg_write,
  output logic               mem_write,
  output logic               adr_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         result_src,
  output logic               alu_op,
  output logic [1:0]         flag_write,
  output logic [STATE_W-1:0] state_o
);

  logic [STATE_W-1:0] r_state;
  logic [3:0]         w_st;
  logic [3:0]         w_next;
  logic               w_ready;
  ctrl_t              w_raw;
  logic               w_rw;
  logic               w_pc;

`ifdef MULTICYCLE_CTRL_MEM_READY_EN
  assign w_ready = mem_ready;
`else
  logic w_unused_ready;
  assign w_unused_ready = mem_ready;
  assign w_ready = 1'b1;
`endif

  assign w_st = r_state[3:0];

  multicycle_ctrl_decode u_decode (
    .i_state (w_st),
    .i_funct (funct[4:0]),
    .o_ctrl  (w_raw)
  );

  // Next-state selection; stray codes fall back to FETCH
  always_comb begin
    w_next = ST_FETCH;
    case (w_st)
      ST_FETCH:
        w_next = w_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        unique case (1'b1)
          (op == OP_MEM):
            w_next = ST_MEMADR;
          (op == OP_DP) && !funct[5]:
            w_next = ST_EXECR;
          (op == OP_DP) && funct[5]:
            w_next = ST_EXECI;
          (op == OP_BR):
            w_next = ST_BRANCH;
          default:
            w_next = ST_FETCH;
        endcase
      end
      ST_MEMADR:
        w_next = funct[0] ? ST_MEMREAD : ST_MEMWRITE;
      ST_MEMREAD:
        w_next = w_ready ? ST_MEMWB : ST_MEMREAD;
      ST_MEMWRITE:
        w_next = w_ready ? ST_FETCH : ST_MEMWRITE;
      ST_EXECR, ST_EXECI:
        w_next = ST_ALUWB;
      default:
        w_next = ST_FETCH;
    endcase
  end

  // State register; reset parks the FSM in FETCH at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= STATE_W'(ST_FETCH);
    else        r_state <= STATE_W'(w_next);
  end

  // Register write that survives cond_ex; rd=15 also redirects PC
  assign w_rw = w_raw.reg_write & cond_ex;

  assign w_pc = (w_raw.pc_fetch & w_ready)
              | (w_raw.pc_branch & cond_ex)
              | (w_rw & (rd == 4'd15));

  assign ir_write   = reset & w_raw.ir_write & w_ready;
  assign pc_write   = reset & w_pc;
  assign reg_write  = reset & w_rw;
  assign mem_write  = reset & w_raw.mem_write & cond_ex;
  assign flag_write = {2{reset & cond_ex}} & w_raw.flag_write;

  assign adr_src    = w_raw.adr_src;
  assign alu_src_a  = w_raw.alu_src_a;
  assign alu_src_b  = w_raw.alu_src_b;
  assign result_src = w_raw.result_src;
  assign alu_op     = w_raw.alu_op;
  assign state_o    = r_state;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm.
// Covers MULTICYCLE_CTRL_MEM_READY_EN when defined.
module tb_multicycle_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       cond_ex;
  logic       mem_ready;
  logic       ir_write, pc_write, reg_write, mem_write, adr_src;
  logic [1:0] alu_src_a, alu_src_b, result_src, flag_write;
  logic       alu_op;
  logic [3:0] state_o;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [13:0] V_F   = 14'b1100_0_01_10_10_0_00;
  localparam logic [13:0] V_D   = 14'b0000_0_01_10_10_0_00;
  localparam logic [13:0] V_MA  = 14'b0000_0_00_01_00_0_00;
  localparam logic [13:0] V_MR  = 14'b0000_1_00_00_00_0_00;

  multicycle_ctrl_fsm #(.STATE_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .rd         (rd),
    .cond_ex    (cond_ex),
    .mem_ready  (mem_ready),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .mem_write  (mem_write),
    .adr_src    (adr_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .result_src (result_src),
    .alu_op     (alu_op),
    .flag_write (flag_write),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] obs();
    return {ir_write, pc_write, reg_write, mem_write,
            adr_src, alu_src_a, alu_src_b, result_src,
            alu_op, flag_write};
  endfunction

  function automatic logic [5:0] strobes();
    return {ir_write, pc_write, reg_write,
            mem_write, flag_write};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (state_o !== 4'd0 || strobes() !== 6'd0
          || alu_src_b !== 2'b10) begin
        n_bad++;
        $display("FAIL reset_hold cyc%0d: state %0d strobes %b, want 0 / 000000",
                 i, state_o, strobes());
      end
      tick();
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (obs() !== V_F || state_o !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_release: state %0d outs %b, want 0 / %b",
               state_o, obs(), V_F);
    end
    tick();
    n_cmp++;
    if (state_o !== 4'd1 || ir_write !== 1'b0) begin
      n_bad++;
      $display("FAIL first_fetch: state %0d ir %b, want 1 / 0",
               state_o, ir_write);
    end
    tick();
  endtask

  task automatic test_ldr();
    logic [3:0]  st[5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    logic [13:0] ex[5] = '{V_F, V_D, V_MA, V_MR,
                           14'b0010_0_00_00_01_0_00};
    op = 2'b01; funct = 6'b011001; rd = 4'd2; cond_ex = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (state_o !== st[i] || obs() !== ex[i]) begin
        n_bad++;
        $display("FAIL ldr step%0d: state %0d outs %b, want %0d / %b",
                 i, state_o, obs(), st[i], ex[i]);
      end
      tick();
    end
    n_cmp++;
    if (state_o !== 4'd0) begin
      n_bad++;
      $display("FAIL ldr_end: state %0d, want 0", state_o);
    end
  endtask

  task automatic test_str_nocond();
    logic [3:0]  st[4] = '{4'd0, 4'd1, 4'd2, 4'd5};
    logic [13:0] ex[4] = '{V_F, V_D, V_MA, V_MR};
    op = 2'b01; funct = 6'b011000; rd = 4'd4; cond_ex = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (state_o !== st[i] || obs() !== ex[i]) begin
        n_bad++;
        $display("FAIL str_nocond step%0d: state %0d outs %b, want %0d / %b",
                 i, state_o, obs(), st[i], ex[i]);
      end
      tick();
    end
    n_cmp++;
    if (state_o !== 4'd0) begin
      n_bad++;
      $display("FAIL str_end: state %0d, want 0", state_o);
    end
  endtask

  task automatic test_adds();
    logic [3:0]  rds[2] = '{4'd3, 4'd15};
    logic [13:0] wb[2]  = '{14'b0010_0_00_00_00_0_00,
                            14'b0110_0_00_00_00_0_00};
    logic [3:0]  st[4]  = '{4'd0, 4'd1, 4'd7, 4'd8};
    logic [13:0] ex[4];
    op = 2'b00; funct = 6'b101001; cond_ex = 1'b1;
    for (int k = 0; k < 2; k++) begin
      rd = rds[k];
      ex = '{V_F, V_D, 14'b0000_0_00_01_00_1_11, wb[k]};
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (state_o !== st[i] || obs() !== ex[i]) begin
          n_bad++;
          $display("FAIL adds rd%0d step%0d: state %0d outs %b, want %0d / %b",
                   rds[k], i, state_o, obs(), st[i], ex[i]);
        end
        tick();
      end
    end
  endtask

  task automatic test_flags();
    logic [5:0]  fn[2]  = '{6'b010101, 6'b011001};
    logic [13:0] exr[2] = '{14'b0000_0_00_00_00_1_11,
                            14'b0000_0_00_00_00_1_10};
    logic [13:0] wb[2]  = '{14'b0000_0_00_00_00_0_00,
                            14'b0010_0_00_00_00_0_00};
    logic [3:0]  st[4]  = '{4'd0, 4'd1, 4'd6, 4'd8};
    logic [13:0] ex[4];
    op = 2'b00; rd = 4'd15; cond_ex = 1'b1;
    for (int k = 0; k < 2; k++) begin
      funct = fn[k];
      if (k == 1) rd = 4'd5;
      ex = '{V_F, V_D, exr[k], wb[k]};
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (state_o !== st[i] || obs() !== ex[i]) begin
          n_bad++;
          $display("FAIL dpreg f%b step%0d: state %0d outs %b, want %0d / %b",
                   fn[k], i, state_o, obs(), st[i], ex[i]);
        end
        tick();
      end
    end
  endtask

  task automatic test_branch();
    logic [13:0] eb[2] = '{14'b0000_0_10_01_10_0_00,
                           14'b0100_0_10_01_10_0_00};
    logic [3:0]  st[3] = '{4'd0, 4'd1, 4'd9};
    logic [13:0] ex[3];
    op = 2'b10; funct = 6'b100000; rd = 4'd0;
    for (int k = 0; k < 2; k++) begin
      cond_ex = k[0];
      ex = '{V_F, V_D, eb[k]};
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (state_o !== st[i] || obs() !== ex[i]) begin
          n_bad++;
          $display("FAIL branch c%0d step%0d: state %0d outs %b, want %0d / %b",
                   k, i, state_o, obs(), st[i], ex[i]);
        end
        tick();
      end
    end
  endtask

  task automatic test_illegal();
    op = 2'b11; funct = 6'b000000; cond_ex = 1'b1;
    tick();
    n_cmp++;
    if (state_o !== 4'd1 || obs() !== V_D) begin
      n_bad++;
      $display("FAIL illegal_decode: state %0d outs %b, want 1 / %b",
               state_o, obs(), V_D);
    end
    tick();
    n_cmp++;
    if (state_o !== 4'd0) begin
      n_bad++;
      $display("FAIL illegal_end: state %0d, want 0", state_o);
    end
  endtask

  task automatic test_reset_memwrite();
    op = 2'b01; funct = 6'b011000; rd = 4'd1; cond_ex = 1'b1;
    tick(); tick(); tick();
    n_cmp++;
    if (state_o !== 4'd5 || mem_write !== 1'b1) begin
      n_bad++;
      $display("FAIL str_memwrite: state %0d mw %b, want 5 / 1",
               state_o, mem_write);
    end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (state_o !== 4'd0 || strobes() !== 6'd0) begin
      n_bad++;
      $display("FAIL async_reset: state %0d strobes %b, want 0 / 000000",
               state_o, strobes());
    end
    op = 2'b11;
    @(negedge clk);
    reset = 1'b1;
    tick();
    n_cmp++;
    if (state_o !== 4'd1) begin
      n_bad++;
      $display("FAIL post_reset_fetch: state %0d, want 1", state_o);
    end
    tick();
  endtask

`ifdef MULTICYCLE_CTRL_MEM_READY_EN
  task automatic test_mem_ready();
    int pulses = 0;
    op = 2'b11; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) mem_ready = 1'b1;
      #1;
      if (ir_write === 1'b1) pulses++;
      n_cmp++;
      if (state_o !== 4'd0 || pc_write !== ir_write) begin
        n_bad++;
        $display("FAIL fetch_wait cyc%0d: state %0d pc %b ir %b, want 0 and pc==ir",
                 i, state_o, pc_write, ir_write);
      end
      tick();
    end
    n_cmp++;
    if (state_o !== 4'd1 || pulses != 1) begin
      n_bad++;
      $display("FAIL fetch_ready: state %0d pulses %0d, want 1 / 1",
               state_o, pulses);
    end
    tick();
    op = 2'b01; funct = 6'b011000; cond_ex = 1'b1;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    tick();
    n_cmp++;
    if (state_o !== 4'd5 || mem_write !== 1'b1) begin
      n_bad++;
      $display("FAIL memwrite_hold: state %0d mw %b, want 5 / 1",
               state_o, mem_write);
    end
    mem_ready = 1'b1;
    tick();
    n_cmp++;
    if (state_o !== 4'd0) begin
      n_bad++;
      $display("FAIL memwrite_done: state %0d, want 0", state_o);
    end
  endtask
`else
  task automatic test_mem_ready();
    mem_ready = 1'b0;
    op = 2'b10; cond_ex = 1'b1;
    tick(); tick();
    n_cmp++;
    if (state_o !== 4'd9 || pc_write !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_ignored: state %0d pc %b, want 9 / 1",
               state_o, pc_write);
    end
    tick();
    n_cmp++;
    if (state_o !== 4'd0) begin
      n_bad++;
      $display("FAIL ready_ignored_end: state %0d, want 0", state_o);
    end
    mem_ready = 1'b1;
  endtask
`endif

  initial begin
    op = 2'b11; funct = '0; rd = '0;
    cond_ex = 1'b0; mem_ready = 1'b1;
    test_reset();
    test_ldr();
    test_str_nocond();
    test_adds();
    test_flags();
    test_branch();
    test_illegal();
    test_reset_memwrite();
    test_mem_ready();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
